// File: rtl/wisc_trace_checker.sv
// rtl/wisc_trace_checker.sv - commit-trace checker comparing CPU events against a golden FIFO
module wisc_trace_checker #(
    parameter int ARCH_WIDTH   = 16,
    parameter int REG_WIDTH    = 4,
    parameter int DEPTH        = 16,
    parameter int CNT_WIDTH    = 32,
    parameter bit STOP_ON_FAIL = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     exp_valid,
    output logic                     exp_ready,
    input  logic [1:0]               exp_kind,
    input  logic [ARCH_WIDTH-1:0]    exp_key,
    input  logic [ARCH_WIDTH-1:0]    exp_value,
    input  logic                     Halt,
    input  logic                     RegWrite,
    input  logic [REG_WIDTH-1:0]     WriteRegister,
    input  logic [ARCH_WIDTH-1:0]    WriteData,
    input  logic                     MemRead,
    input  logic                     MemWrite,
    input  logic [ARCH_WIDTH-1:0]    MemAddress,
    input  logic [ARCH_WIDTH-1:0]    MemDataIn,
    input  logic [ARCH_WIDTH-1:0]    MemDataOut,
    output logic                     done,
    output logic                     pass,
    output logic                     fail,
    output logic [2:0]               err_code,
    output logic [CNT_WIDTH-1:0]     match_count,
    output logic [CNT_WIDTH-1:0]     mismatch_count,
    output logic [CNT_WIDTH-1:0]     fail_idx,
    output logic [ARCH_WIDTH-1:0]    fail_exp_key,
    output logic [ARCH_WIDTH-1:0]    fail_exp_value,
    output logic [ARCH_WIDTH-1:0]    fail_act_key,
    output logic [ARCH_WIDTH-1:0]    fail_act_value,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;
    localparam logic [1:0] K_REG   = 2'd0;
    localparam logic [1:0] K_LOAD  = 2'd1;
    localparam logic [1:0] K_STORE = 2'd2;
    localparam logic [1:0] K_HALT  = 2'd3;

    typedef enum logic {S_RUN, S_DONE} state_t;

    state_t                 state, state_nx;
    logic [1:0]             mem_kind  [DEPTH];
    logic [ARCH_WIDTH-1:0]  mem_key   [DEPTH];
    logic [ARCH_WIDTH-1:0]  mem_value [DEPTH];
    logic [AW-1:0]          head, tail, head_nx;
    logic [OW-1:0]          occ, occ_nx;
    logic [2:0]             settle;
    logic [CNT_WIDTH-1:0]   event_idx, event_idx_nx;

    logic                   push;
    logic [1:0]             ev_kind [4];
    logic [ARCH_WIDTH-1:0]  ev_key  [4];
    logic [ARCH_WIDTH-1:0]  ev_val  [4];
    logic [2:0]             n_ev, n_good, n_bad, err_i;
    logic [OW-1:0]          n_pop, left;
    logic [AW-1:0]          rd_idx;
    logic                   err_now, leftover;

    logic                   done_nx, pass_nx, fail_nx;
    logic [2:0]             err_code_nx;
    logic [CNT_WIDTH-1:0]   match_nx, mismatch_nx, fail_idx_nx;
    logic [ARCH_WIDTH-1:0]  fexp_key_nx, fexp_val_nx, fact_key_nx, fact_val_nx;

    assign occupancy = occ;
    // Ready looks only at registered occupancy so a same-cycle pop never frees a slot early.
    assign exp_ready = (occ < OW'(DEPTH)) && (state == S_RUN);
    assign push      = exp_valid && exp_ready;

    always_comb begin
        state_nx     = state;
        head_nx      = head;
        occ_nx       = occ;
        event_idx_nx = event_idx;
        fail_nx      = fail;
        err_code_nx  = err_code;
        match_nx     = match_count;
        mismatch_nx  = mismatch_count;
        fail_idx_nx  = fail_idx;
        fexp_key_nx  = fail_exp_key;
        fexp_val_nx  = fail_exp_value;
        fact_key_nx  = fail_act_key;
        fact_val_nx  = fail_act_value;
        n_ev         = '0;
        n_good       = '0;
        n_bad        = '0;
        err_i        = '0;
        err_now      = 1'b0;
        leftover     = 1'b0;
        rd_idx       = '0;
        left         = '0;
        for (int i = 0; i < 4; i++) begin
            ev_kind[i] = K_REG;
            ev_key[i]  = '0;
            ev_val[i]  = '0;
        end

        // Event order mirrors the trace file: REG, LOAD, STORE, HALT.
        if (RegWrite && !(settle < 3'd4 && WriteRegister == '0)) begin
            ev_kind[n_ev[1:0]] = K_REG;
            ev_key[n_ev[1:0]]  = ARCH_WIDTH'(WriteRegister);
            ev_val[n_ev[1:0]]  = WriteData;
            n_ev = n_ev + 3'd1;
        end
        if (MemRead) begin
            ev_kind[n_ev[1:0]] = K_LOAD;
            ev_key[n_ev[1:0]]  = MemAddress;
            ev_val[n_ev[1:0]]  = MemDataOut;
            n_ev = n_ev + 3'd1;
        end
        if (MemWrite) begin
            ev_kind[n_ev[1:0]] = K_STORE;
            ev_key[n_ev[1:0]]  = MemAddress;
            ev_val[n_ev[1:0]]  = MemDataIn;
            n_ev = n_ev + 3'd1;
        end
        if (Halt) begin
            ev_kind[n_ev[1:0]] = K_HALT;
            n_ev = n_ev + 3'd1;
        end

        n_pop = (OW'(n_ev) > occ) ? occ : OW'(n_ev);

        if (state == S_RUN) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(n_ev)) begin
                    rd_idx = head + i[AW-1:0];
                    if (OW'(i) >= occ)
                        err_i = 3'd3;
                    else if (mem_kind[rd_idx] != ev_kind[i])
                        err_i = 3'd2;
                    else if (ev_kind[i] != K_HALT &&
                             (mem_key[rd_idx] != ev_key[i] || mem_value[rd_idx] != ev_val[i]))
                        err_i = 3'd1;
                    else
                        err_i = 3'd0;

                    if (err_i != 3'd0) begin
                        n_bad = n_bad + 3'd1;
                        if (!fail && !err_now) begin
                            err_now     = 1'b1;
                            err_code_nx = err_i;
                            fail_idx_nx = event_idx + CNT_WIDTH'(i);
                            fexp_key_nx = (err_i == 3'd3) ? '0 : mem_key[rd_idx];
                            fexp_val_nx = (err_i == 3'd3) ? '0 : mem_value[rd_idx];
                            fact_key_nx = ev_key[i];
                            fact_val_nx = ev_val[i];
                        end
                    end else begin
                        n_good = n_good + 3'd1;
                    end
                end
            end

            left = occ - n_pop;
            if (Halt && left != '0) begin
                leftover = 1'b1;
                if (!fail && !err_now) begin
                    rd_idx      = head + n_pop[AW-1:0];
                    err_code_nx = 3'd4;
                    fail_idx_nx = event_idx + CNT_WIDTH'(n_ev) - CNT_WIDTH'(1);
                    fexp_key_nx = mem_key[rd_idx];
                    fexp_val_nx = mem_value[rd_idx];
                    fact_key_nx = '0;
                    fact_val_nx = '0;
                end
            end

            head_nx      = head + n_pop[AW-1:0];
            occ_nx       = occ + OW'(push) - n_pop;
            event_idx_nx = event_idx + CNT_WIDTH'(n_ev);
            match_nx     = match_count + CNT_WIDTH'(n_good);
            mismatch_nx  = mismatch_count + CNT_WIDTH'(n_bad) + CNT_WIDTH'(leftover);
            fail_nx      = fail || (n_bad != '0) || leftover;
            if (Halt || (STOP_ON_FAIL && ((n_bad != '0) || leftover)))
                state_nx = S_DONE;
        end

        done_nx = (state_nx == S_DONE);
        pass_nx = done_nx && !fail_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= S_RUN;
            head           <= '0;
            tail           <= '0;
            occ            <= '0;
            settle         <= '0;
            event_idx      <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            err_code       <= '0;
            match_count    <= '0;
            mismatch_count <= '0;
            fail_idx       <= '0;
            fail_exp_key   <= '0;
            fail_exp_value <= '0;
            fail_act_key   <= '0;
            fail_act_value <= '0;
        end else begin
            state          <= state_nx;
            head           <= head_nx;
            if (push)
                tail <= tail + 1'b1;
            occ            <= occ_nx;
            if (settle != 3'd4)
                settle <= settle + 3'd1;
            event_idx      <= event_idx_nx;
            done           <= done_nx;
            pass           <= pass_nx;
            fail           <= fail_nx;
            err_code       <= err_code_nx;
            match_count    <= match_nx;
            mismatch_count <= mismatch_nx;
            fail_idx       <= fail_idx_nx;
            fail_exp_key   <= fexp_key_nx;
            fail_exp_value <= fexp_val_nx;
            fail_act_key   <= fact_key_nx;
            fail_act_value <= fact_val_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_kind[tail]  <= exp_kind;
            mem_key[tail]   <= exp_key;
            mem_value[tail] <= exp_value;
        end
    end
endmodule

// File: tb/tb_wisc_trace_checker.sv
// tb/tb_wisc_trace_checker.sv - scoreboard bench for wisc_trace_checker
module tb_wisc_trace_checker;
    localparam int AW    = 16;
    localparam int RW    = 4;
    localparam int DEPTH = 16;
    localparam int CW    = 32;

    localparam int F_DONE  = 0;
    localparam int F_PASS  = 1;
    localparam int F_FAIL  = 2;
    localparam int F_ERR   = 3;
    localparam int F_MATCH = 4;
    localparam int F_MISM  = 5;
    localparam int F_FIDX  = 6;
    localparam int F_FEXPV = 7;
    localparam int F_FACTV = 8;
    localparam int F_OCC   = 9;
    localparam int F_READY = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic exp_valid = 1'b0;
    logic exp_ready;
    logic [1:0] exp_kind = '0;
    logic [AW-1:0] exp_key = '0, exp_value = '0;
    logic Halt = 1'b0, RegWrite = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
    logic [RW-1:0] WriteRegister = '0;
    logic [AW-1:0] WriteData = '0, MemAddress = '0, MemDataIn = '0, MemDataOut = '0;
    logic done, pass, fail;
    logic [2:0] err_code;
    logic [CW-1:0] match_count, mismatch_count, fail_idx;
    logic [AW-1:0] fail_exp_key, fail_exp_value, fail_act_key, fail_act_value;
    logic [$clog2(DEPTH):0] occupancy;

    wisc_trace_checker #(
        .ARCH_WIDTH(AW), .REG_WIDTH(RW), .DEPTH(DEPTH), .CNT_WIDTH(CW), .STOP_ON_FAIL(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_kind(exp_kind),
        .exp_key(exp_key), .exp_value(exp_value),
        .Halt(Halt), .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemAddress(MemAddress),
        .MemDataIn(MemDataIn), .MemDataOut(MemDataOut),
        .done(done), .pass(pass), .fail(fail), .err_code(err_code),
        .match_count(match_count), .mismatch_count(mismatch_count), .fail_idx(fail_idx),
        .fail_exp_key(fail_exp_key), .fail_exp_value(fail_exp_value),
        .fail_act_key(fail_act_key), .fail_act_value(fail_act_value),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          fid;
        logic [31:0] val;
        string       name;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  pend;
    logic acc;
    logic [31:0] got;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] get_field(input int fid);
        case (fid)
            F_DONE:  return 32'(done);
            F_PASS:  return 32'(pass);
            F_FAIL:  return 32'(fail);
            F_ERR:   return 32'(err_code);
            F_MATCH: return match_count;
            F_MISM:  return mismatch_count;
            F_FIDX:  return fail_idx;
            F_FEXPV: return 32'(fail_exp_value);
            F_FACTV: return 32'(fail_act_value);
            F_OCC:   return 32'(occupancy);
            F_READY: return 32'(exp_ready);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: pops every expectation due this cycle and compares at the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            got = get_field(mon_e.fid);
            checks++;
            if (mon_e.cyc != cyc || got !== mon_e.val) begin
                failures++;
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, due %0d)",
                         mon_e.name, got, mon_e.val, cyc, mon_e.cyc);
            end
        end
    end

    task automatic expect_f(input int fid, input logic [31:0] val, input string name);
        sb_t e;
        e.cyc = cyc; e.fid = fid; e.val = val; e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ev();
        Halt = 0; RegWrite = 0; MemRead = 0; MemWrite = 0;
        WriteRegister = '0; WriteData = '0; MemAddress = '0; MemDataIn = '0; MemDataOut = '0;
    endtask

    task automatic do_reset();
        clear_ev();
        exp_valid = 0; exp_kind = '0; exp_key = '0; exp_value = '0;
        rst = 0;
        tick();
        tick();
        rst = 1;
    endtask

    task automatic settle_wait();
        for (int i = 0; i < 5; i++) tick();
    endtask

    task automatic push_e(input logic [1:0] k, input logic [15:0] key, input logic [15:0] val);
        exp_valid = 1; exp_kind = k; exp_key = key; exp_value = val;
        tick();
        exp_valid = 0;
    endtask

    task automatic reg_ev(input logic [3:0] r, input logic [15:0] d);
        RegWrite = 1; WriteRegister = r; WriteData = d;
        tick();
        clear_ev();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Basic REG / STORE / HALT run
        do_reset();
        expect_f(F_DONE, 0, "rst_done");
        expect_f(F_FAIL, 0, "rst_fail");
        expect_f(F_ERR, 0, "rst_err");
        expect_f(F_MATCH, 0, "rst_match");
        expect_f(F_OCC, 0, "rst_occ");
        expect_f(F_READY, 1, "rst_ready");
        settle_wait();
        push_e(2'd0, 16'h0003, 16'h00A5);
        push_e(2'd2, 16'h0010, 16'h1234);
        push_e(2'd3, 16'h0000, 16'h0000);
        expect_f(F_OCC, 3, "t1_occ3");
        reg_ev(4'd3, 16'h00A5);
        expect_f(F_MATCH, 1, "t1_match1");
        MemWrite = 1; MemAddress = 16'h0010; MemDataIn = 16'h1234;
        tick(); clear_ev();
        expect_f(F_MATCH, 2, "t1_match2");
        Halt = 1;
        tick(); clear_ev();
        expect_f(F_DONE, 1, "t1_done");
        expect_f(F_PASS, 1, "t1_pass");
        expect_f(F_FAIL, 0, "t1_fail");
        expect_f(F_MATCH, 3, "t1_match3");
        expect_f(F_OCC, 0, "t1_occ0");

        // LW cycle: REG and LOAD popped together
        do_reset();
        settle_wait();
        push_e(2'd0, 16'h0002, 16'hBEEF);
        push_e(2'd1, 16'h0020, 16'hBEEF);
        RegWrite = 1; WriteRegister = 4'd2; WriteData = 16'hBEEF;
        MemRead = 1; MemAddress = 16'h0020; MemDataOut = 16'hBEEF;
        tick(); clear_ev();
        expect_f(F_MATCH, 2, "t2_match");
        expect_f(F_OCC, 0, "t2_occ");
        expect_f(F_FAIL, 0, "t2_fail");
        expect_f(F_DONE, 0, "t2_done");

        // Value mismatch stops the checker; DONE freezes everything
        do_reset();
        settle_wait();
        push_e(2'd0, 16'h0001, 16'h0001);
        reg_ev(4'd1, 16'h0002);
        expect_f(F_FAIL, 1, "t3_fail");
        expect_f(F_ERR, 1, "t3_err");
        expect_f(F_FIDX, 0, "t3_fidx");
        expect_f(F_FEXPV, 16'h0001, "t3_fexpv");
        expect_f(F_FACTV, 16'h0002, "t3_factv");
        expect_f(F_DONE, 1, "t3_done");
        expect_f(F_PASS, 0, "t3_pass");
        expect_f(F_MISM, 1, "t3_mism");
        expect_f(F_READY, 0, "t3_ready_done");
        reg_ev(4'd1, 16'h0001);
        expect_f(F_MATCH, 0, "t3_frozen_match");
        expect_f(F_MISM, 1, "t3_frozen_mism");

        // R0 writes ignored while settling, then underflow once settled
        do_reset();
        tick();
        reg_ev(4'd0, 16'h0000);
        expect_f(F_OCC, 0, "t4_occ");
        expect_f(F_FAIL, 0, "t4_nop_fail");
        expect_f(F_MISM, 0, "t4_nop_mism");
        tick();
        tick();
        reg_ev(4'd0, 16'h0000);
        expect_f(F_ERR, 3, "t4_underflow_err");
        expect_f(F_FAIL, 1, "t4_underflow_fail");
        expect_f(F_DONE, 1, "t4_done");
        expect_f(F_FIDX, 0, "t4_fidx");

        // Kind mismatch
        do_reset();
        settle_wait();
        push_e(2'd2, 16'h0001, 16'h0001);
        reg_ev(4'd1, 16'h0001);
        expect_f(F_ERR, 2, "t5_kind_err");
        expect_f(F_MISM, 1, "t5_kind_mism");

        // Full FIFO, refused push while popping, then wrap through 40 events
        do_reset();
        settle_wait();
        for (int k = 0; k < 16; k++) push_e(2'd0, {12'b0, k[3:0]}, 16'h1000 + k[15:0]);
        expect_f(F_OCC, 16, "t6_full_occ");
        expect_f(F_READY, 0, "t6_full_ready");
        pend = 16;
        for (int j = 0; j < 40; j++) begin
            RegWrite = 1; WriteRegister = j[3:0]; WriteData = 16'h1000 + j[15:0];
            exp_valid = (pend < 40); exp_kind = 2'd0;
            exp_key = {12'b0, pend[3:0]}; exp_value = 16'h1000 + pend[15:0];
            acc = exp_valid && exp_ready;
            tick();
            if (acc) pend++;
            expect_f(F_MATCH, j + 1, "t6_wrap_match");
            if (j == 0) begin
                expect_f(F_OCC, 15, "t6_refused_occ");
                expect_f(F_READY, 1, "t6_ready_again");
            end
            if (j == 1) expect_f(F_OCC, 15, "t6_pushpop_occ");
        end
        clear_ev();
        exp_valid = 0;
        expect_f(F_OCC, 0, "t6_drained_occ");
        expect_f(F_FAIL, 0, "t6_fail");

        // Leftover entry at halt
        do_reset();
        settle_wait();
        push_e(2'd0, 16'h0005, 16'h0055);
        push_e(2'd2, 16'h0030, 16'h0077);
        push_e(2'd3, 16'h0000, 16'h0000);
        push_e(2'd0, 16'h0006, 16'h0066);
        reg_ev(4'd5, 16'h0055);
        MemWrite = 1; MemAddress = 16'h0030; MemDataIn = 16'h0077;
        tick(); clear_ev();
        Halt = 1;
        tick(); clear_ev();
        expect_f(F_DONE, 1, "t7_done");
        expect_f(F_FAIL, 1, "t7_fail");
        expect_f(F_ERR, 4, "t7_err");
        expect_f(F_MISM, 1, "t7_mism");
        expect_f(F_MATCH, 3, "t7_match");
        expect_f(F_PASS, 0, "t7_pass");

        tick();
        tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
